laser_array: RTL and testbench

- Parametrised successor to the single-beam laser: N_BEAMS parallel beams fired from the player ship.
- Shared charge/fire/cooldown FSM paced by an internal game tick.
- Per-pixel colour from parameter colours, not a ROM. Sits in the playfield pixel pipeline beside the player and enemy layers.
- The compositor consumes `rgb_out` and `laser_on` one clock after x/y.

---
 rtl/laser_pkg.sv | 19 +
 rtl/laser_tick_gen.sv | 26 ++
 rtl/laser_array.sv | 190 +++++++++++++++++++
 tb/tb_laser_array.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/laser_pkg.sv
// Shared definitions for the laser beam blocks: FSM state encoding,
// beam colours and default playfield size.
package laser_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CHARGE   = 2'd1,
        FIRE     = 2'd2,
        COOLDOWN = 2'd3
    } beam_state_e;

    localparam logic [11:0] WARN_RGB = 12'h44F;
    localparam logic [11:0] CORE_RGB = 12'hFFF;
    localparam logic [11:0] EDGE_RGB = 12'h6CF;

    localparam int DEF_MAX_X = 384;
    localparam int DEF_MAX_Y = 448;

endpackage

// File: rtl/laser_tick_gen.sv
// Free-running game tick divider: one-cycle pulse every TICK_DIV clocks,
// first pulse TICK_DIV cycles after reset release.
module laser_tick_gen #(
    parameter int TICK_DIV = 2000000
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == W'(TICK_DIV - 1));

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

endmodule

// File: rtl/laser_array.sv
// Multi-beam player laser: shared charge/fire/cooldown FSM plus a registered
// per-pixel colour stage. Define LASER_HITBOX_EN for the enemy hit detector.
module laser_array
    import laser_pkg::*;
#(
    parameter int N_BEAMS      = 3,
    parameter int BEAM_W       = 16,
    parameter int SPACING      = 24,
    parameter int MAX_X        = DEF_MAX_X,
    parameter int MAX_Y        = DEF_MAX_Y,
    parameter int TICK_DIV     = 2000000,
    parameter int CHARGE_TICKS = 8,
    parameter int FIRE_MIN     = 4,
    parameter int FIRE_MAX     = 60,
    parameter int COOL_TICKS   = 20
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [9:0]         x,
    input  logic [9:0]         y,
    input  logic [9:0]         player_x,
    input  logic [9:0]         player_y,
    input  logic               shooting,
    input  logic [N_BEAMS-1:0] beam_en,
    output logic [11:0]        rgb_out,
    output logic               laser_on,
    output logic [1:0]         beam_state,
    output logic               tick_out
`ifdef LASER_HITBOX_EN
    ,
    input  logic [9:0]         enemy_x0,
    input  logic [9:0]         enemy_x1,
    input  logic [9:0]         enemy_y0,
    input  logic [9:0]         enemy_y1,
    output logic               enemy_hit
`endif
);

    localparam int CNT_W = 8;
    localparam int HALF  = BEAM_W / 2;
    localparam int SPAN  = ((N_BEAMS - 1) * SPACING) / 2;
    localparam logic [9:0]        RST_OX = 10'(MAX_X / 2 - HALF);
    localparam logic [9:0]        RST_OY = 10'(MAX_Y - 49);
    localparam logic signed [11:0] OX_MAX = 12'(MAX_X - BEAM_W);

    beam_state_e                   state_q, state_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d, cnt_inc;
    logic [N_BEAMS-1:0]            mask_q, mask_d;
    logic [N_BEAMS-1:0][9:0]       ox_q, ox_d, ox_new;
    logic [9:0]                    oy_q, oy_d, oy_new;
    logic [11:0]                   rgb_q, rgb_d;
    logic                          on_q, on_d;
    logic                          tick;
    logic [N_BEAMS-1:0]            hit_fire, hit_core, hit_warn;

    laser_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    assign tick_out   = tick;
    assign beam_state = state_q;
    assign rgb_out    = rgb_q;
    assign laser_on   = on_q;
    assign oy_new     = (player_y == 10'd0) ? 10'd0 : player_y - 10'd1;

`ifdef LASER_HITBOX_EN
    logic [N_BEAMS-1:0] box_hit;
    // Uses the currently latched geometry, i.e. before this tick's re-latch.
    assign enemy_hit = tick && (state_q == FIRE) && (|box_hit);
`endif

    for (genvar i = 0; i < N_BEAMS; i++) begin : g_beam
        logic signed [11:0] raw;
        logic [10:0]        xe, oxe;

        assign raw = 12'(player_x) + 12'(i * SPACING - SPAN - HALF);
        assign ox_new[i] = (raw < 12'sd0) ? 10'd0 :
                           (raw > OX_MAX) ? OX_MAX[9:0] : raw[9:0];

        assign xe  = {1'b0, x};
        assign oxe = {1'b0, ox_q[i]};
        assign hit_fire[i] = mask_q[i] && (xe >= oxe) && (xe < oxe + 11'(BEAM_W));
        assign hit_core[i] = (xe >= oxe + 11'(HALF - 2)) && (xe <= oxe + 11'(HALF + 1));
        assign hit_warn[i] = mask_q[i] &&
                             ((xe == oxe + 11'(HALF - 1)) || (xe == oxe + 11'(HALF)));

`ifdef LASER_HITBOX_EN
        assign box_hit[i] = mask_q[i] && (oxe <= {1'b0, enemy_x1}) &&
                            (oxe + 11'(BEAM_W - 1) >= {1'b0, enemy_x0}) &&
                            (enemy_y0 < oy_q) && (enemy_y1 >= enemy_y0);
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        cnt_inc = cnt_q + 1'b1;
        if (tick) begin
            if (state_q == CHARGE || state_q == FIRE) begin
                mask_d = beam_en;
                ox_d   = ox_new;
                oy_d   = oy_new;
            end
            case (state_q)
                IDLE: begin
                    if (shooting) begin
                        state_d = CHARGE;
                        cnt_d   = '0;
                    end
                end
                CHARGE: begin
                    if (!shooting) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_inc == CNT_W'(CHARGE_TICKS)) begin
                        state_d = FIRE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                FIRE: begin
                    // Releasing the button early still fires for FIRE_MIN ticks.
                    if (cnt_inc == CNT_W'(FIRE_MAX) ||
                        (!shooting && cnt_inc >= CNT_W'(FIRE_MIN))) begin
                        state_d = COOLDOWN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                COOLDOWN: begin
                    if (cnt_inc == CNT_W'(COOL_TICKS)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Walk beams high to low so the lowest index overwrites the colour last.
    always_comb begin
        rgb_d = '0;
        on_d  = 1'b0;
        if (({1'b0, x} < 11'(MAX_X)) && ({1'b0, y} < 11'(MAX_Y)) && (y < oy_q)) begin
            for (int i = N_BEAMS - 1; i >= 0; i--) begin
                if (state_q == FIRE && hit_fire[i]) begin
                    on_d  = 1'b1;
                    rgb_d = hit_core[i] ? CORE_RGB : EDGE_RGB;
                end else if (state_q == CHARGE && hit_warn[i]) begin
                    on_d  = 1'b1;
                    rgb_d = WARN_RGB;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mask_q  <= '0;
            ox_q    <= {N_BEAMS{RST_OX}};
            oy_q    <= RST_OY;
            rgb_q   <= '0;
            on_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            rgb_q   <= rgb_d;
            on_q    <= on_d;
        end
    end

endmodule

// File: tb/tb_laser_array.sv
// Randomised scoreboard bench for laser_array against a tick-level game model.
`timescale 1ns/1ps
module tb_laser_array;

    localparam int N     = 3;
    localparam int W     = 16;
    localparam int SP    = 24;
    localparam int MX    = 384;
    localparam int MY    = 448;
    localparam int TDIV  = 4;
    localparam int CHG   = 2;
    localparam int FMIN  = 3;
    localparam int FMAX  = 8;
    localparam int COOL  = 2;
    localparam logic [11:0] C_WARN = 12'h44F;
    localparam logic [11:0] C_CORE = 12'hFFF;
    localparam logic [11:0] C_EDGE = 12'h6CF;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [9:0]   x, y, player_x, player_y;
    logic         shooting;
    logic [N-1:0] beam_en;
    logic [11:0]  rgb_out;
    logic         laser_on;
    logic [1:0]   beam_state;
    logic         tick_out;
`ifdef LASER_HITBOX_EN
    logic [9:0]   enemy_x0, enemy_x1, enemy_y0, enemy_y1;
    logic         enemy_hit;
`endif

    always #5 clk = ~clk;

    laser_array #(
        .N_BEAMS(N), .BEAM_W(W), .SPACING(SP), .MAX_X(MX), .MAX_Y(MY),
        .TICK_DIV(TDIV), .CHARGE_TICKS(CHG), .FIRE_MIN(FMIN),
        .FIRE_MAX(FMAX), .COOL_TICKS(COOL)
    ) dut (
        .clk(clk), .reset_n(reset_n), .x(x), .y(y),
        .player_x(player_x), .player_y(player_y), .shooting(shooting),
        .beam_en(beam_en), .rgb_out(rgb_out), .laser_on(laser_on),
        .beam_state(beam_state), .tick_out(tick_out)
`ifdef LASER_HITBOX_EN
        , .enemy_x0(enemy_x0), .enemy_x1(enemy_x1), .enemy_y0(enemy_y0),
        .enemy_y1(enemy_y1), .enemy_hit(enemy_hit)
`endif
    );

    typedef struct {
        logic [11:0] rgb;
        bit          on;
        int          st;
        bit          tk;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Game model: state 0..3, ticks spent in state, clock count within a tick.
    int     m_st, m_tc, m_tcnt, m_oy;
    int     m_ox[N];
    bit [N-1:0] m_mask;

    function automatic int ox_of(int i, int px);
        int v;
        v = px + i * SP - ((N - 1) * SP) / 2 - W / 2;
        if (v < 0) v = 0;
        if (v > MX - W) v = MX - W;
        return v;
    endfunction

    task automatic model_reset();
        m_st = 0; m_tc = 0; m_tcnt = 0; m_mask = '0;
        for (int i = 0; i < N; i++) m_ox[i] = MX / 2 - W / 2;
        m_oy = MY - 49;
    endtask

    function automatic void pix(input int px, input int py,
                                output logic [11:0] c, output bit on);
        bit hit;
        logic [11:0] col;
        c = '0; on = 0;
        if (px >= MX || py >= MY || py >= m_oy) return;
        for (int i = 0; i < N; i++) begin
            hit = 0; col = '0;
            if (m_mask[i] && m_st == 2) begin
                hit = (px >= m_ox[i]) && (px < m_ox[i] + W);
                col = (px >= m_ox[i] + W/2 - 2 && px <= m_ox[i] + W/2 + 1) ? C_CORE : C_EDGE;
            end else if (m_mask[i] && m_st == 1) begin
                hit = (px == m_ox[i] + W/2 - 1) || (px == m_ox[i] + W/2);
                col = C_WARN;
            end
            if (hit && !on) begin
                c = col; on = 1;
            end
        end
    endfunction

    task automatic advance();
        if (m_st == 1 || m_st == 2) begin
            m_mask = beam_en;
            for (int i = 0; i < N; i++) m_ox[i] = ox_of(i, int'(player_x));
            m_oy = (player_y > 0) ? int'(player_y) - 1 : 0;
        end
        case (m_st)
            0: if (shooting) begin m_st = 1; m_tc = 0; end
            1: if (!shooting) begin m_st = 0; m_tc = 0; end
               else begin
                   m_tc++;
                   if (m_tc == CHG) begin m_st = 2; m_tc = 0; end
               end
            2: begin
                   m_tc++;
                   if (m_tc == FMAX || (!shooting && m_tc >= FMIN)) begin m_st = 3; m_tc = 0; end
               end
            default: begin
                   m_tc++;
                   if (m_tc == COOL) begin m_st = 0; m_tc = 0; end
               end
        endcase
    endtask

`ifdef LASER_HITBOX_EN
    function automatic bit box_model();
        bit r = 0;
        for (int i = 0; i < N; i++)
            if (m_mask[i] && m_ox[i] <= int'(enemy_x1) && m_ox[i] + W - 1 >= int'(enemy_x0) &&
                int'(enemy_y0) <= m_oy - 1 && enemy_y1 >= enemy_y0)
                r = 1;
        return r;
    endfunction
`endif

    // Called at a negedge with inputs already applied; returns at the next negedge.
    task automatic cycle();
        exp_t e;
        logic [11:0] c;
        bit on, tick_now;
        if (!reset_n) begin
            model_reset();
            e.rgb = '0; e.on = 0; e.st = 0; e.tk = 0;
        end else begin
            pix(int'(x), int'(y), c, on);
            tick_now = (m_tcnt == TDIV - 1);
`ifdef LASER_HITBOX_EN
            #1;
            n_cmp++;
            if (enemy_hit !== (tick_now && m_st == 2 && box_model())) begin
                n_err++;
                $display("FAIL enemy_hit: got %b want %b at %0t", enemy_hit,
                         tick_now && m_st == 2 && box_model(), $time);
            end
`endif
            if (tick_now) advance();
            m_tcnt = tick_now ? 0 : m_tcnt + 1;
            e.rgb = c; e.on = on; e.st = m_st; e.tk = (m_tcnt == TDIV - 1);
        end
        q.push_back(e);
        @(negedge clk);
    endtask

    int xs[22] = '{0, 159, 160, 161, 175, 176, 183, 184, 190, 191, 192,
                   193, 199, 200, 208, 215, 216, 223, 224, 383, 384, 1023};
    int ys[7]  = '{0, 10, 398, 399, 400, 447, 448};

    task automatic run(int n);
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 1) == 0) begin
                x = 10'(xs[$urandom_range(0, 21)]);
                y = 10'(ys[$urandom_range(0, 6)]);
            end else begin
                x = 10'($urandom_range(0, 3) == 0 ? $urandom_range(0, 1023) : $urandom_range(0, 240));
                y = 10'($urandom_range(0, 460));
            end
            cycle();
        end
    endtask

    task automatic wait_state(int s);
        for (int k = 0; k < 200 && m_st != s; k++) run(1);
        if (m_st != s) begin
            n_cmp++; n_err++;
            $display("FAIL wait_state: model stuck in %0d, wanted %0d", m_st, s);
        end
    endtask

    // Monitor: every registered output is due one clock after its inputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_cmp += 4;
                if (rgb_out !== e.rgb) begin
                    n_err++; $display("FAIL rgb_out: got %h want %h at %0t", rgb_out, e.rgb, $time);
                end
                if (laser_on !== e.on) begin
                    n_err++; $display("FAIL laser_on: got %b want %b at %0t", laser_on, e.on, $time);
                end
                if (int'(beam_state) != e.st) begin
                    n_err++; $display("FAIL beam_state: got %0d want %0d at %0t", beam_state, e.st, $time);
                end
                if (tick_out !== e.tk) begin
                    n_err++; $display("FAIL tick_out: got %b want %b at %0t", tick_out, e.tk, $time);
                end
            end
        end
    end

    initial begin
        reset_n = 0; shooting = 0; beam_en = '0;
        player_x = 10'd192; player_y = 10'd400; x = '0; y = '0;
`ifdef LASER_HITBOX_EN
        enemy_x0 = 10'd200; enemy_x1 = 10'd210; enemy_y0 = 10'd50; enemy_y1 = 10'd60;
`endif
        model_reset();
        @(negedge clk);
        run(3);
        reset_n = 1;

        // Full charge/fire/cooldown cycle with the button held.
        shooting = 1; beam_en = 3'b111;
        run(60);

        // Reset in the middle of FIRE.
        wait_state(2);
        run(6);
        reset_n = 0; run(2); reset_n = 1;

        // Abort during CHARGE.
        shooting = 1; wait_state(1);
        run(2); shooting = 0; run(10);

        // Early release one tick into FIRE.
        shooting = 1; wait_state(2);
        run(4); shooting = 0; run(30);

        // Left-edge clamp, then single-beam mask through CHARGE and FIRE.
        player_x = 10'd5; beam_en = 3'b111; shooting = 1; run(50);
        player_x = 10'd192; beam_en = 3'b010; run(60);
        beam_en = 3'b001; run(40);

        // Random play with occasional resets.
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 15) == 0) shooting = ~shooting;
            if ($urandom_range(0, 31) == 0) player_x = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 31) == 0) player_y = 10'($urandom_range(0, 500));
            if ($urandom_range(0, 7) == 0)  beam_en = N'($urandom);
`ifdef LASER_HITBOX_EN
            if ($urandom_range(0, 63) == 0) begin
                enemy_x0 = 10'($urandom_range(0, 383));
                enemy_x1 = enemy_x0 + 10'($urandom_range(0, 40));
                enemy_y0 = 10'($urandom_range(0, 447));
                enemy_y1 = enemy_y0 + 10'($urandom_range(0, 40));
            end
`endif
            if ($urandom_range(0, 499) == 0) begin
                reset_n = 0; run(1); reset_n = 1;
            end
            run(1);
        end

        @(posedge clk); #2;
        n_cmp++;
        if (q.size() != 0) begin
            n_err++; $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
